hazard_unit: RTL and testbench
==============================

# hazard_unit

Stall/flush controller between decode and the ID/EX pipeline register of the 16-bit in-order pipeline; the pipeline has no forwarding. Keeps a 3-deep scoreboard of destination registers in flight (EX, MEM, WB) and stalls decode while a source register is pending. Converts the instruction in ID into a bubble (`controlZeroIdEx`) on a stall or a taken redirect, and flushes IF/ID on redirect. Sequences processor halt: drains the pipeline, then holds the front end.

## Interface
- `STALL_CNT_W`, 16: width of the saturating stall-cycle counter.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `idValid`  in  1  ID holds a real instruction (not a bubble).
- `idRs`, `idRt`  in  3 each  source register numbers of the ID instruction.
- `idRsValid`, `idRtValid`  in  1 each  source is actually read.
- `idWriteReg`  in  3  destination register of the ID instruction.
- `idWriteRegValid`  in  1  destination field meaningful.
- `idRegWrite`  in  1  ID instruction writes the register file.
- `idHalt`  in  1  ID instruction is HALT.
- `exRedirect`  in  1  branch taken or jump resolved in EX this cycle.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `controlZeroIdEx`  out  1  load a bubble into ID/EX this cycle.
- `flushIfId`  out  1  replace IF/ID contents with a bubble at next edge.
- `haltDone`  out  1  pipeline drained after HALT; front end frozen.
- `stallCount`  out  `STALL_CNT_W`  saturating count of stall cycles.

## Operation
- Scoreboard: slots S0 (EX), S1 (MEM), S2 (WB), each {v, reg[2:0]}. Each edge: S2<=S1, S1<=S0, S0<=issued entry.
- Issued entry = {idValid & idRegWrite & idWriteRegValid, idWriteReg} when the ID instruction advances; {0,x} when bubbled.
- The register file does not bypass a same-cycle write to a read: the WB slot counts as pending. R0 is an ordinary register; no exclusion.
- hazard = idValid & ((idRsValid & match(idRs)) | (idRtValid & match(idRt))), match(r) = any Si.v & Si.reg==r.
- Priority: exRedirect > hazard.
- exRedirect=1: flushIfId=1, controlZeroIdEx=1, stall=0, S0 loads bubble. The ID instruction is wrong-path and killed; any hazard is ignored.
- Else hazard=1: stall=1, controlZeroIdEx=1, S0 loads bubble, stallCount increments (saturates at all-ones).
- Else: all three outputs 0, ID instruction issues into S0.
- FSM RUN → DRAIN when a HALT issues (idValid & idHalt, not stalled, no redirect). The HALT itself enters S0 like any instruction.
- FSM DRAIN → HALTED when S0, S1 and S2 are all invalid and a 3-edge drain counter has expired.
- In DRAIN and HALTED: stall=1, controlZeroIdEx=1, flushIfId=0, and stallCount does not count.
- In DRAIN, exRedirect still flushes IF/ID (flushIfId=1).
- HALTED is terminal until reset; haltDone=1 only in HALTED.

## Timing
- stall, controlZeroIdEx and flushIfId are combinational from current inputs and registered state, and act at the coming edge.
- Hazard clears one cycle after the producing entry leaves S2. Worst case is a dependent instruction directly after its producer: 3 stall cycles, and the instruction issues in the 4th cycle.
- haltDone rises 3 edges after the HALT issues.
- Reset (asynchronous, any time, including mid-stall or in DRAIN): all slots invalid, FSM=RUN, drain counter=0, stallCount=0, haltDone=0. With idValid=0 this gives stall=0, controlZeroIdEx=0, flushIfId=0.
- Simultaneous hazard and exRedirect: redirect wins, and the cycle is not counted as a stall.

## Structure
- Shared package: FSM state enum {RUN, DRAIN, HALTED}, scoreboard entry struct {v, reg}, `SB_DEPTH`=3, `REG_W`=3.
- One sub-module: `sb_match`, combinational. Takes a register number plus the 3 slots and returns the match bit. Instantiated twice, once for Rs and once for Rt.
- Ports wire directly to the IF/ID register (stall, flushIfId), PC register (stall) and ID/EX register (controlZeroIdEx).

## Test plan
- RAW back-to-back: ADD R3←R1,R2 then ADD R4←R3,R1 → stall=1 and controlZeroIdEx=1 for exactly 3 cycles; second ADD issues in cycle 4; stallCount=3.
- Independent stream: 8 instructions with no shared registers → stall never asserts; S0..S2 track destinations; stallCount=0.
- Redirect during hazard: ID is stalled on R5 and exRedirect=1 → flushIfId=1, controlZeroIdEx=1, stall=0; the next cycle has no stall from the killed instruction.
- Non-reading source: idRtValid=0 with idRt=3 while R3 is pending → no stall.
- Halt: HALT issues with 2 older writers in flight → stall held from the next cycle; haltDone=1 exactly 3 edges after issue; it stays 1 for 20 further cycles.
- Async reset asserted mid-DRAIN with the scoreboard full → outputs return to 0 immediately without a clock; after release a fresh instruction issues with no stall.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the decode hazard / halt controller.
//   haltState_e : halt sequencer states (RUN, DRAIN, HALTED)
//   sbEntry_t   : one scoreboard slot {v, regNum}
//   SB_DEPTH    : number of in-flight stages tracked (EX, MEM, WB)
//   REG_W       : register-number width
package hazard_unit_pkg;

  localparam int SB_DEPTH = 3;
  localparam int REG_W    = 3;

  // Edges spent in DRAIN before HALTED may be entered; with a non-writing
  // HALT this is exactly the time it takes the HALT to pass WB.
  localparam int DRAIN_EDGES = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } haltState_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] regNum;
  } sbEntry_t;

endpackage

// File: rtl/hazard_unit_sb_match.sv
// Combinational scoreboard lookup.
//   regNum : register number to look up
//   slots  : scoreboard slots, index 0 = EX, 1 = MEM, 2 = WB
//   match  : some valid slot targets regNum
module sb_match
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0]         regNum,
  input  sbEntry_t [SB_DEPTH-1:0]  slots,
  output logic                     match
);

  // The WB slot is included: the register file does not bypass a write to a
  // read in the same cycle, so a value in WB is still pending.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (slots[i].v && (slots[i].regNum == regNum)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush / halt controller between decode and the ID/EX register of
// the 16-bit in-order pipeline (no forwarding).
//   clk, rst                  : clock, asynchronous active-low reset
//   idValid                   : ID holds a real instruction
//   idRs/idRt, idRsValid/...  : source registers and whether they are read
//   idWriteReg, idWriteRegValid, idRegWrite : destination of the ID instruction
//   idHalt                    : ID instruction is HALT
//   exRedirect                : taken branch / jump resolved in EX
//   stall                     : hold PC and IF/ID
//   controlZeroIdEx           : load a bubble into ID/EX
//   flushIfId                 : replace IF/ID with a bubble
//   haltDone                  : pipeline drained after HALT, front end frozen
//   stallCount                : saturating count of hazard stall cycles
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 16
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idValid,
  input  logic [REG_W-1:0]       idRs,
  input  logic [REG_W-1:0]       idRt,
  input  logic                   idRsValid,
  input  logic                   idRtValid,
  input  logic [REG_W-1:0]       idWriteReg,
  input  logic                   idWriteRegValid,
  input  logic                   idRegWrite,
  input  logic                   idHalt,
  input  logic                   exRedirect,
  output logic                   stall,
  output logic                   controlZeroIdEx,
  output logic                   flushIfId,
  output logic                   haltDone,
  output logic [STALL_CNT_W-1:0] stallCount
);

  sbEntry_t [SB_DEPTH-1:0] slots;
  sbEntry_t                issuedEntry;
  haltState_e              state;
  haltState_e              stateNext;
  logic [1:0]              drainCnt;
  logic                    rsMatch;
  logic                    rtMatch;
  logic                    hazard;
  logic                    issue;
  logic                    countStall;
  logic                    slotsEmpty;
  logic                    drainExpired;

  sb_match uRsMatch (
    .regNum (idRs),
    .slots  (slots),
    .match  (rsMatch)
  );

  sb_match uRtMatch (
    .regNum (idRt),
    .slots  (slots),
    .match  (rtMatch)
  );

  assign hazard       = idValid & ((idRsValid & rsMatch) | (idRtValid & rtMatch));
  assign drainExpired = (drainCnt >= 2'(DRAIN_EDGES - 1));
  assign haltDone     = (state == HALTED);

  // The drain is finished only once nothing in flight is still valid.
  always_comb begin
    slotsEmpty = 1'b1;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (slots[i].v) begin
        slotsEmpty = 1'b0;
      end
    end
  end

  // Pipeline control and halt sequencing. A redirect kills the ID
  // instruction outright, so it takes priority over a hazard and is never
  // counted as a stall. Once a HALT has issued, the front end is held.
  always_comb begin
    stall           = 1'b0;
    controlZeroIdEx = 1'b0;
    flushIfId       = 1'b0;
    issue           = 1'b0;
    countStall      = 1'b0;
    stateNext       = state;
    unique case (state)
      RUN: begin
        if (exRedirect) begin
          flushIfId       = 1'b1;
          controlZeroIdEx = 1'b1;
        end else if (hazard) begin
          stall           = 1'b1;
          controlZeroIdEx = 1'b1;
          countStall      = 1'b1;
        end else begin
          issue = 1'b1;
          if (idValid && idHalt) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        stall           = 1'b1;
        controlZeroIdEx = 1'b1;
        flushIfId       = exRedirect;
        if (slotsEmpty && drainExpired) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        stall           = 1'b1;
        controlZeroIdEx = 1'b1;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Entry pushed into the EX slot: the ID destination when it advances,
  // otherwise an invalid bubble.
  always_comb begin
    issuedEntry.v      = issue & idValid & idRegWrite & idWriteRegValid;
    issuedEntry.regNum = issue ? idWriteReg : '0;
  end

  // Scoreboard shift EX -> MEM -> WB and halt state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots <= '0;
      state <= RUN;
    end else begin
      slots[2] <= slots[1];
      slots[1] <= slots[0];
      slots[0] <= issuedEntry;
      state    <= stateNext;
    end
  end

  // Drain counter only advances while draining; it saturates at 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drainCnt <= 2'd0;
    end else if ((state == DRAIN) && (drainCnt != 2'd3)) begin
      drainCnt <= drainCnt + 2'd1;
    end
  end

  // Saturating hazard stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= '0;
    end else if (countStall && (stallCount != '1)) begin
      stallCount <= stallCount + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table-driven vectors, hand-written
// halt / reset / saturation sequences, and randomized stimulus checked
// against a behavioural model built from pending-register history.
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             idValid;
  logic [2:0]       idRs;
  logic [2:0]       idRt;
  logic             idRsValid;
  logic             idRtValid;
  logic [2:0]       idWriteReg;
  logic             idWriteRegValid;
  logic             idRegWrite;
  logic             idHalt;
  logic             exRedirect;
  logic             stall;
  logic             controlZeroIdEx;
  logic             flushIfId;
  logic             haltDone;
  logic [CNT_W-1:0] stallCount;

  always #5 clk = ~clk;

  hazard_unit #(.STALL_CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .idValid         (idValid),
    .idRs            (idRs),
    .idRt            (idRt),
    .idRsValid       (idRsValid),
    .idRtValid       (idRtValid),
    .idWriteReg      (idWriteReg),
    .idWriteRegValid (idWriteRegValid),
    .idRegWrite      (idRegWrite),
    .idHalt          (idHalt),
    .exRedirect      (exRedirect),
    .stall           (stall),
    .controlZeroIdEx (controlZeroIdEx),
    .flushIfId       (flushIfId),
    .haltDone        (haltDone),
    .stallCount      (stallCount)
  );

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic       v;
    logic [2:0] rs;
    logic       rsV;
    logic [2:0] rt;
    logic       rtV;
    logic [2:0] wr;
    logic       wrV;
    logic       regWr;
    logic       halt;
    logic       redir;
    logic       eStall;
    logic       eCz;
    logic       eFlush;
    int         eCount;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: destinations written in the last three issue slots
  // (-1 = nothing), and the number of edges since a HALT issued.
  int pend[3];
  bit haltIssued;
  int haltAge;
  int modelCount;

  function automatic vec_t mk(input logic v, input logic [2:0] rs, input logic rsV,
                              input logic [2:0] rt, input logic rtV, input logic [2:0] wr,
                              input logic wrV, input logic regWr, input logic halt,
                              input logic redir, input logic eStall, input logic eCz,
                              input logic eFlush, input int eCount);
    vec_t r;
    r.v = v; r.rs = rs; r.rsV = rsV; r.rt = rt; r.rtV = rtV; r.wr = wr;
    r.wrV = wrV; r.regWr = regWr; r.halt = halt; r.redir = redir;
    r.eStall = eStall; r.eCz = eCz; r.eFlush = eFlush; r.eCount = eCount;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic rsV,
                               input logic [2:0] rt, input logic rtV, input logic [2:0] wr,
                               input logic wrV, input logic regWr, input logic halt,
                               input logic redir);
    idValid = v; idRs = rs; idRsValid = rsV; idRt = rt; idRtValid = rtV;
    idWriteReg = wr; idWriteRegValid = wrV; idRegWrite = regWr;
    idHalt = halt; exRedirect = redir;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic eStall, input logic eCz,
                             input logic eFlush, input logic eDone, input int eCount);
    checkCount++;
    if (stall !== eStall) begin
      failCount++;
      $display("[TB] FAIL %s stall: got %b expected %b", name, stall, eStall);
    end
    checkCount++;
    if (controlZeroIdEx !== eCz) begin
      failCount++;
      $display("[TB] FAIL %s controlZeroIdEx: got %b expected %b", name, controlZeroIdEx, eCz);
    end
    checkCount++;
    if (flushIfId !== eFlush) begin
      failCount++;
      $display("[TB] FAIL %s flushIfId: got %b expected %b", name, flushIfId, eFlush);
    end
    checkCount++;
    if (haltDone !== eDone) begin
      failCount++;
      $display("[TB] FAIL %s haltDone: got %b expected %b", name, haltDone, eDone);
    end
    checkCount++;
    if ($isunknown(stallCount) || (int'(stallCount) != eCount)) begin
      failCount++;
      $display("[TB] FAIL %s stallCount: got %0d expected %0d", name, stallCount, eCount);
    end
  endtask

  function automatic bit isPending(input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      if (pend[k] == int'(r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) pend[k] = -1;
    haltIssued = 0;
    haltAge    = 0;
    modelCount = 0;
  endtask

  // Predict this cycle's outputs, compare, then advance across the next edge.
  task automatic modelStep(input string name);
    bit hz, eS, eC, eF, eD, issueNow;
    hz = idValid && ((idRsValid && isPending(idRs)) || (idRtValid && isPending(idRt)));
    eD = haltIssued && (haltAge >= 3);
    issueNow = 0;
    if (eD) begin
      eS = 1; eC = 1; eF = 0;
    end else if (haltIssued) begin
      eS = 1; eC = 1; eF = exRedirect;
    end else if (exRedirect) begin
      eS = 0; eC = 1; eF = 1;
    end else if (hz) begin
      eS = 1; eC = 1; eF = 0;
    end else begin
      eS = 0; eC = 0; eF = 0; issueNow = 1;
    end
    checkOutput(name, eS, eC, eF, eD, modelCount);
    if (!haltIssued && !exRedirect && hz && (modelCount < CNT_MAX)) modelCount++;
    pend[2] = pend[1];
    pend[1] = pend[0];
    pend[0] = (issueNow && idValid && idRegWrite && idWriteRegValid) ? int'(idWriteReg) : -1;
    if (haltIssued) haltAge++;
    else if (issueNow && idValid && idHalt) begin
      haltIssued = 1;
      haltAge    = 0;
    end
  endtask

  // Asynchronous reset pulse; outputs are checked while reset is held.
  task automatic doReset(input string name);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    checkOutput(name, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    #1;
    checkOutput("resetHeld", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("resetRelease", 0, 0, 0, 0, 0);

    // RAW back-to-back, non-reading source, redirect during hazard, R0.
    vecs.push_back(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 3, 1, 1, 1, 4, 1, 1, 0, 0, 1, 1, 0, k));
    vecs.push_back(mk(1, 3, 1, 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 1, 4, 0, 5, 1, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 5, 1, 0, 0, 7, 1, 1, 0, 1, 0, 1, 1, 3));
    vecs.push_back(mk(1, 7, 1, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4));
    // Independent stream: reads are never among the last three destinations.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 3'((k + 5) % 8), 1, 3'((k + 5) % 8), 1, 3'((k + 1) % 8),
                        1, 1, 0, 0, 0, 0, 0, 4));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].v, vecs[i].rs, vecs[i].rsV, vecs[i].rt, vecs[i].rtV,
                    vecs[i].wr, vecs[i].wrV, vecs[i].regWr, vecs[i].halt, vecs[i].redir);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].eStall, vecs[i].eCz, vecs[i].eFlush,
                  1'b0, vecs[i].eCount);
    end

    // HALT with two older writers in flight.
    doReset("haltReset");
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); #1;
    checkOutput("haltW1", 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); #1;
    checkOutput("haltW2", 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    checkOutput("haltIssue", 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 1, 1, 0, 0, 3, 1, 1, 0, 1); #1;
    checkOutput("drain1", 1, 1, 1, 0, 0);
    @(negedge clk); applyStimulus(1, 1, 1, 0, 0, 3, 1, 1, 0, 0); #1;
    checkOutput("drain2", 1, 1, 0, 0, 0);
    @(negedge clk); #1;
    checkOutput("drain3", 1, 1, 0, 0, 0);
    @(negedge clk); #1;
    checkOutput("haltDone", 1, 1, 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      applyStimulus(1, 1, 1, 2, 1, 3, 1, 1, 0, 1'(k % 2));
      #1;
      checkOutput($sformatf("halted%0d", k), 1, 1, 0, 1, 0);
    end

    // Async reset mid-DRAIN with the scoreboard full.
    doReset("drainReset");
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 3'(k), 1, 1, 0, 0); #1;
      checkOutput($sformatf("fillW%0d", k), 0, 0, 0, 0, 0);
    end
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 1, 0); #1;
    checkOutput("fillHalt", 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 4, 1, 3, 1, 5, 1, 1, 0, 0); #1;
    checkOutput("fullDrain", 1, 1, 0, 0, 0);
    #2;
    idle();
    rst = 1'b0;
    #1;
    checkOutput("midDrainReset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 4, 1, 3, 1, 5, 1, 1, 0, 0);
    #1;
    checkOutput("freshIssue", 0, 0, 0, 0, 0);
    @(negedge clk); idle(); #1;
    checkOutput("afterFresh", 0, 0, 0, 0, 0);

    // Saturation: repeated producer / dependent pairs.
    doReset("satReset");
    modelReset();
    for (int p = 0; p < 6; p++) begin
      @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); #1;
      modelStep($sformatf("satW%0d", p));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); applyStimulus(1, 1, 1, 2, 0, 2, 0, 0, 0, 0); #1;
        modelStep($sformatf("satR%0d_%0d", p, k));
      end
    end
    @(negedge clk); idle(); #1;
    checkOutput("saturated", 0, 0, 0, 0, CNT_MAX);

    // Randomized stimulus against the model.
    doReset("randReset");
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      logic h;
      if (haltIssued && (haltAge > 10)) begin
        doReset($sformatf("randReset%0d", n));
        modelReset();
      end
      @(negedge clk);
      h = ($urandom_range(0, 39) == 0);
      applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                    3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom), h ? 1'b0 : 1'($urandom), h,
                    ($urandom_range(0, 7) == 0));
      #1;
      modelStep($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
